// File: rtl/cam_pixel_capture.sv
// DVP camera receiver: assembles 1..3 sensor bytes per pixel and tags each
// pixel with X/Y, start-of-frame and end-of-line, checking line/frame geometry.
module cam_pixel_capture #(
  parameter int DATA_W      = 8,
  parameter int BPP         = 2,
  parameter int MSB_FIRST   = 1,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 1
) (
  input  logic                                pclk_i,
  input  logic                                rst_i,
  input  logic [DATA_W-1:0]                   d_i,
  input  logic                                vsync_i,
  input  logic                                href_i,
  input  logic                                enable_i,
  output logic [DATA_W*BPP-1:0]               pixel_o,
  output logic                                pixel_valid_o,
  output logic [$clog2(H_ACTIVE+1)-1:0]       x_o,
  output logic [$clog2(V_ACTIVE+1)-1:0]       y_o,
  output logic                                sof_o,
  output logic                                eol_o,
  output logic                                frame_valid_o,
  output logic                                frame_done_o,
  output logic                                line_err_o,
  output logic                                frame_err_o
);

  localparam int PIX_W = DATA_W * BPP;
  localparam int XW    = $clog2(H_ACTIVE + 1);
  localparam int YW    = $clog2(V_ACTIVE + 1);
  localparam int BW    = (BPP > 1) ? $clog2(BPP) : 1;

  localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE);
  localparam logic [BW-1:0] B_LAST = BW'(BPP - 1);
  localparam logic [3:0]    SKIP_N = 4'(SKIP_FRAMES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_VS = 3'd1;
  localparam logic [2:0] S_SKIP    = 3'd2;
  localparam logic [2:0] S_ARMED   = 3'd3;
  localparam logic [2:0] S_ACTIVE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [3:0]       skip_q, skip_d;
  logic [XW-1:0]    x_q, x_d, xo_q, xo_d;
  logic [YW-1:0]    y_q, y_d, yo_q, yo_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             x_ovf_q, x_ovf_d, y_ovf_q, y_ovf_d;
  logic             vs_q, hr_q;
  logic [PIX_W-1:0] asm_q, asm_d, pixel_q, pixel_d;
  logic             pv_q, pv_d, sof_q, sof_d, eol_q, eol_d;
  logic             done_q, done_d, lerr_q, lerr_d, ferr_q, ferr_d;

  logic vs_rise, vs_fall, hr_fall;

  assign vs_rise = vsync_i & ~vs_q;
  assign vs_fall = ~vsync_i & vs_q;
  assign hr_fall = ~href_i & hr_q;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d = state_q;
    skip_d  = skip_q;
    x_d     = x_q;
    y_d     = y_q;
    bcnt_d  = bcnt_q;
    x_ovf_d = x_ovf_q;
    y_ovf_d = y_ovf_q;
    asm_d   = asm_q;
    pixel_d = pixel_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    pv_d    = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: if (enable_i) state_d = S_WAIT_VS;
      S_WAIT_VS: begin
        if (!enable_i) state_d = S_IDLE;
        else if (vsync_i) begin
          state_d = (SKIP_FRAMES == 0) ? S_ARMED : S_SKIP;
          skip_d  = '0;
        end
      end
      S_SKIP: begin
        if (!enable_i) state_d = S_IDLE;
        else if (vs_rise) begin
          skip_d = skip_q + 4'd1;
          if (skip_q + 4'd1 == SKIP_N) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!enable_i) state_d = S_IDLE;
        else if (vs_fall) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          bcnt_d  = '0;
          x_ovf_d = 1'b0;
          y_ovf_d = 1'b0;
        end
      end
      S_ACTIVE: begin
        // Counters saturate; the overflow flags keep over-long lines/frames visible as errors.
        if (hr_fall) begin
          lerr_d  = (x_q != X_MAX) || (bcnt_q != '0) || x_ovf_q;
          x_d     = '0;
          bcnt_d  = '0;
          x_ovf_d = 1'b0;
          if (y_q == Y_MAX) y_ovf_d = 1'b1;
          else              y_d     = y_q + YW'(1);
        end else if (href_i && !vsync_i) begin
          for (int k = 0; k < BPP; k++) begin
            if (bcnt_q == BW'(k))
              asm_d[((MSB_FIRST != 0) ? (BPP - 1 - k) : k) * DATA_W +: DATA_W] = d_i;
          end
          if (bcnt_q == B_LAST) begin
            bcnt_d = '0;
            if ((x_q < X_MAX) && (y_q < Y_MAX)) begin
              pixel_d = asm_d;
              pv_d    = 1'b1;
              xo_d    = x_q;
              yo_d    = y_q;
              sof_d   = (x_q == '0) && (y_q == '0);
              eol_d   = (x_q == X_LAST);
            end
            if (x_q == X_MAX) x_ovf_d = 1'b1;
            else              x_d     = x_q + XW'(1);
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
        if (vs_rise) begin
          done_d  = 1'b1;
          ferr_d  = (y_d != Y_MAX) || y_ovf_d;
          state_d = enable_i ? S_ARMED : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      bcnt_q  <= '0;
      x_ovf_q <= 1'b0;
      y_ovf_q <= 1'b0;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      asm_q   <= '0;
      pixel_q <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      pv_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bcnt_q  <= bcnt_d;
      x_ovf_q <= x_ovf_d;
      y_ovf_q <= y_ovf_d;
      vs_q    <= vsync_i;
      // href seen during vertical blanking never opens a line.
      hr_q    <= href_i & ~vsync_i;
      asm_q   <= asm_d;
      pixel_q <= pixel_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      pv_q    <= pv_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign pixel_o       = pixel_q;
  assign pixel_valid_o = pv_q;
  assign x_o           = xo_q;
  assign y_o           = yo_q;
  assign sof_o         = sof_q;
  assign eol_o         = eol_q;
  assign frame_valid_o = (state_q == S_ACTIVE);
  assign frame_done_o  = done_q;
  assign line_err_o    = lerr_q;
  assign frame_err_o   = ferr_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture: drivers queue expected output events
// (with their cycle), per-instance monitors pop and compare on every DUT output.
module tb_cam_pixel_capture;

  localparam int H = 4;
  localparam int V = 2;

  typedef struct {
    bit pv; bit done; bit lerr; bit ferr; bit sof; bit eol;
    int pix; int x; int y; int cyc;
  } ev_t;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  ev_t q_a[$];
  ev_t q_b[$];

  // Instance A: RGB565-style, MSB first, 4x2 frame, one skip frame.
  logic        a_rst, a_en, a_vs, a_hr;
  logic [7:0]  a_d;
  logic [15:0] a_pix;
  logic [2:0]  a_x;
  logic [1:0]  a_y;
  logic        a_pv, a_sof, a_eol, a_fv, a_done, a_lerr, a_ferr;

  cam_pixel_capture #(.DATA_W(8), .BPP(2), .MSB_FIRST(1), .H_ACTIVE(H), .V_ACTIVE(V),
                      .SKIP_FRAMES(1)) dut_a (
    .pclk_i(pclk), .rst_i(a_rst), .d_i(a_d), .vsync_i(a_vs), .href_i(a_hr), .enable_i(a_en),
    .pixel_o(a_pix), .pixel_valid_o(a_pv), .x_o(a_x), .y_o(a_y), .sof_o(a_sof), .eol_o(a_eol),
    .frame_valid_o(a_fv), .frame_done_o(a_done), .line_err_o(a_lerr), .frame_err_o(a_ferr));

  // Instance B: RGB888, LSB first, no skip frames.
  logic        b_rst, b_en, b_vs, b_hr;
  logic [7:0]  b_d;
  logic [23:0] b_pix;
  logic [2:0]  b_x;
  logic [1:0]  b_y;
  logic        b_pv, b_sof, b_eol, b_fv, b_done, b_lerr, b_ferr;

  cam_pixel_capture #(.DATA_W(8), .BPP(3), .MSB_FIRST(0), .H_ACTIVE(H), .V_ACTIVE(V),
                      .SKIP_FRAMES(0)) dut_b (
    .pclk_i(pclk), .rst_i(b_rst), .d_i(b_d), .vsync_i(b_vs), .href_i(b_hr), .enable_i(b_en),
    .pixel_o(b_pix), .pixel_valid_o(b_pv), .x_o(b_x), .y_o(b_y), .sof_o(b_sof), .eol_o(b_eol),
    .frame_valid_o(b_fv), .frame_done_o(b_done), .line_err_o(b_lerr), .frame_err_o(b_ferr));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_ev(input string tag, input ev_t e, input ev_t o);
    check({tag, "_cycle"}, o.cyc, e.cyc);
    check({tag, "_pixel_valid"}, int'(o.pv), int'(e.pv));
    check({tag, "_frame_done"}, int'(o.done), int'(e.done));
    check({tag, "_line_err"}, int'(o.lerr), int'(e.lerr));
    check({tag, "_frame_err"}, int'(o.ferr), int'(e.ferr));
    check({tag, "_sof"}, int'(o.sof), int'(e.sof));
    check({tag, "_eol"}, int'(o.eol), int'(e.eol));
    if (e.pv) begin
      check({tag, "_pixel"}, o.pix, e.pix);
      check({tag, "_x"}, o.x, e.x);
      check({tag, "_y"}, o.y, e.y);
    end
  endtask

  function automatic ev_t ev_pix(input int pix, input int x, input int y);
    ev_t e = '{default: 0};
    e.pv  = 1'b1;
    e.pix = pix;
    e.x   = x;
    e.y   = y;
    e.sof = (x == 0) && (y == 0);
    e.eol = (x == H - 1);
    e.cyc = cyc;
    return e;
  endfunction

  function automatic ev_t ev_flag(input bit done, input bit lerr, input bit ferr);
    ev_t e = '{default: 0};
    e.done = done;
    e.lerr = lerr;
    e.ferr = ferr;
    e.cyc  = cyc;
    return e;
  endfunction

  always @(negedge pclk) begin
    ev_t o, e;
    if ((a_pv | a_done | a_lerr | a_ferr) === 1'b1) begin
      o = '{pv: a_pv, done: a_done, lerr: a_lerr, ferr: a_ferr, sof: a_sof, eol: a_eol,
            pix: int'(a_pix), x: int'(a_x), y: int'(a_y), cyc: cyc};
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: cycle %0d pv=%0b done=%0b lerr=%0b ferr=%0b pix=0x%0h, required no output",
                 cyc, a_pv, a_done, a_lerr, a_ferr, a_pix);
      end else begin
        e = q_a.pop_front();
        cmp_ev("a", e, o);
      end
    end
  end

  always @(negedge pclk) begin
    ev_t o, e;
    if ((b_pv | b_done | b_lerr | b_ferr) === 1'b1) begin
      o = '{pv: b_pv, done: b_done, lerr: b_lerr, ferr: b_ferr, sof: b_sof, eol: b_eol,
            pix: int'(b_pix), x: int'(b_x), y: int'(b_y), cyc: cyc};
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: cycle %0d pv=%0b done=%0b lerr=%0b ferr=%0b pix=0x%0h, required no output",
                 cyc, b_pv, b_done, b_lerr, b_ferr, b_pix);
      end else begin
        e = q_b.pop_front();
        cmp_ev("b", e, o);
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_pixel"}, int'(a_pix), 0);
    check({tag, "_pixel_valid"}, int'(a_pv), 0);
    check({tag, "_x"}, int'(a_x), 0);
    check({tag, "_y"}, int'(a_y), 0);
    check({tag, "_sof"}, int'(a_sof), 0);
    check({tag, "_eol"}, int'(a_eol), 0);
    check({tag, "_frame_valid"}, int'(a_fv), 0);
    check({tag, "_frame_done"}, int'(a_done), 0);
    check({tag, "_line_err"}, int'(a_lerr), 0);
    check({tag, "_frame_err"}, int'(a_ferr), 0);
  endtask

  // Bytes 0xA0+i; a pixel completes on every odd byte index.
  task automatic send_bytes(input int from, input int to, input bit cap, input int y);
    for (int i = from; i < to; i++) begin
      a_d  = 8'(8'hA0 + i);
      a_hr = 1'b1;
      a_vs = 1'b0;
      tick();
      if (cap && (i % 2 == 1) && (i / 2 < H) && (y < V))
        q_a.push_back(ev_pix((8'hA0 + i - 1) * 256 + 8'hA0 + i, i / 2, y));
    end
  endtask

  task automatic end_line(input bit lerr);
    a_hr = 1'b0;
    tick();
    if (lerr) q_a.push_back(ev_flag(1'b0, 1'b1, 1'b0));
    tick();
    tick();
  endtask

  task automatic run_frame(input int nl, input int len0, input bit cap, input bit drop_en);
    a_vs = 1'b0;
    a_hr = 1'b0;
    tick();
    tick();
    check("frame_valid_in_frame", int'(a_fv), int'(cap));
    if (drop_en) a_en = 1'b0;
    for (int l = 0; l < nl; l++) begin
      int len = (l == 0) ? len0 : 2 * H;
      send_bytes(0, len, cap, l);
      end_line(cap && (len != 2 * H));
    end
    a_vs = 1'b1;
    tick();
    if (cap) q_a.push_back(ev_flag(1'b1, 1'b0, nl != V));
    check("frame_valid_after_vsync", int'(a_fv), 0);
    tick();
    tick();
    tick();
  endtask

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_vs = 1'b1; a_hr = 1'b0; a_d = 8'h00;
    b_rst = 1'b1; b_en = 1'b0; b_vs = 1'b1; b_hr = 1'b0; b_d = 8'h00;
    tick();
    tick();
    check_zero_a("reset");
    a_rst = 1'b0;
    a_en  = 1'b1;
    repeat (4) tick();

    run_frame(2, 8, 1'b0, 1'b0);   // skipped after arming
    run_frame(2, 8, 1'b1, 1'b0);   // first captured frame
    run_frame(2, 8, 1'b1, 1'b0);
    run_frame(2, 7, 1'b1, 1'b0);   // short first line
    run_frame(3, 8, 1'b1, 1'b0);   // one line too many
    run_frame(2, 8, 1'b1, 1'b1);   // enable drops mid-frame, frame still completes
    run_frame(2, 8, 1'b0, 1'b0);   // idle: nothing
    a_en = 1'b1;
    repeat (3) tick();
    run_frame(2, 8, 1'b0, 1'b0);   // skipped again after re-arming
    run_frame(2, 8, 1'b1, 1'b0);

    // Reset during line 1 of a captured frame.
    a_vs = 1'b0;
    a_hr = 1'b0;
    tick();
    tick();
    send_bytes(0, 8, 1'b1, 0);
    end_line(1'b0);
    send_bytes(0, 3, 1'b1, 1);
    a_rst = 1'b1;
    a_d   = 8'hA3;
    tick();
    a_rst = 1'b0;
    check_zero_a("midreset");
    send_bytes(4, 8, 1'b0, 1);
    end_line(1'b0);
    a_vs = 1'b1;
    repeat (4) tick();
    run_frame(2, 8, 1'b0, 1'b0);   // skip frame after reset
    run_frame(2, 8, 1'b1, 1'b0);

    // Instance B: three-byte pixels, LSB first.
    b_rst = 1'b0;
    b_en  = 1'b1;
    repeat (3) tick();
    b_vs = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      b_d  = 8'(8'h11 * (i + 1));
      b_hr = 1'b1;
      tick();
      if (i == 2) q_b.push_back(ev_pix(32'h0033_2211, 0, 0));
      if (i == 5) q_b.push_back(ev_pix(32'h0066_5544, 1, 0));
    end
    b_hr = 1'b0;
    tick();
    q_b.push_back(ev_flag(1'b0, 1'b1, 1'b0));
    tick();
    b_vs = 1'b1;
    tick();
    q_b.push_back(ev_flag(1'b1, 1'b0, 1'b1));
    repeat (3) tick();

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
